// File: rtl/gemm_seq_pkg.sv
// Shared types and constants for the GEMM tile sequencer: FSM states,
// GEMM register offsets and the DIM register field layout.
package gemm_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WR_ASTR,
    S_WR_BSTR,
    S_WR_AADR,
    S_WR_BADR,
    S_WR_CADR,
    S_WR_CTRL,
    S_WR_DIM,
    S_POLL_FULL,
    S_POLL_DONE,
    S_FIN
  } seq_state_e;

  localparam logic [31:0] REG_A_ADDR   = 32'd0;
  localparam logic [31:0] REG_B_ADDR   = 32'd4;
  localparam logic [31:0] REG_C_ADDR   = 32'd8;
  localparam logic [31:0] REG_A_STRIDE = 32'd12;
  localparam logic [31:0] REG_B_STRIDE = 32'd16;
  localparam logic [31:0] REG_CTRL     = 32'd20;
  localparam logic [31:0] REG_DIM      = 32'd24;

  localparam int DIM_K_SHIFT = 5;
  localparam int DIM_N_SHIFT = 10;

  function automatic logic [31:0] pack_dim(logic [4:0] msize, logic [4:0] ksize,
                                           logic [4:0] nsize);
    return 32'(msize) | (32'(ksize) << DIM_K_SHIFT) | (32'(nsize) << DIM_N_SHIFT);
  endfunction

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// System bus between the tile sequencer (master) and the GEMM top (slave).
interface gemm_tile_sequencer_if;
  logic        en;
  logic        rdwr;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output en, rdwr, addr, wr_data, input rd_data);
  modport slave  (input en, rdwr, addr, wr_data, output rd_data);
endinterface

// File: rtl/gemm_tile_sequencer_iter.sv
// Tile walker: n (outer) / m / k (inner) indices, size clamps, first/last
// flags and running address offsets for the current tile.
module gemm_tile_iter
  import gemm_seq_pkg::*;
#(
  parameter int BLK_N = 16,
  parameter int BLK_K = 16,
  parameter int BLK_M = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        advance,
  input  logic [15:0] dim_m,
  input  logic [15:0] dim_k,
  input  logic [15:0] dim_n,
  input  logic [31:0] a_base,
  input  logic [31:0] b_base,
  input  logic [31:0] c_base,
  output logic [31:0] a_addr,
  output logic [31:0] b_addr,
  output logic [31:0] c_addr,
  output logic [1:0]  ctrl,
  output logic [31:0] dim_word,
  output logic        blk_done,
  output logic        all_done
);

  logic [15:0] n_q, n_d, m_q, m_d, k_q, k_d;
  logic [31:0] a_row_q, a_row_d, b_row_q, b_row_d, c_row_q, c_row_d;
  logic [31:0] step_a_q, step_a_d, step_b_q, step_b_d, step_c_q, step_c_d;
  logic [31:0] b_tail_q, b_tail_d, b_last_q, b_last_d;

  logic [16:0] n_end, m_end, k_end;
  logic [15:0] n_rem, m_rem, k_rem;
  logic [4:0]  nsize, msize, ksize;
  logic        n_last, m_last, k_last;

  assign n_end  = {1'b0, n_q} + 17'(BLK_N);
  assign m_end  = {1'b0, m_q} + 17'(BLK_M);
  assign k_end  = {1'b0, k_q} + 17'(BLK_K);
  assign n_last = n_end >= {1'b0, dim_n};
  assign m_last = m_end >= {1'b0, dim_m};
  assign k_last = k_end >= {1'b0, dim_k};

  assign n_rem = dim_n - n_q;
  assign m_rem = dim_m - m_q;
  assign k_rem = dim_k - k_q;
  assign nsize = (n_rem >= 16'(BLK_N)) ? 5'(BLK_N) : n_rem[4:0];
  assign msize = (m_rem >= 16'(BLK_M)) ? 5'(BLK_M) : m_rem[4:0];
  assign ksize = (k_rem >= 16'(BLK_K)) ? 5'(BLK_K) : k_rem[4:0];

  assign blk_done = k_last && m_last;
  assign all_done = blk_done && n_last;
  assign ctrl     = {k_q == 16'd0, k_last};
  assign dim_word = pack_dim(msize, ksize, nsize);

  // B points at the last row of the tile; on the final k tile that row is K-1.
  assign a_addr = a_base + a_row_q + 32'(k_q);
  assign b_addr = b_base + 32'(n_q) + (k_last ? b_last_q : b_row_q + b_tail_q);
  assign c_addr = c_base + 32'(n_q) + c_row_q;

  always_comb begin
    n_d      = n_q;
    m_d      = m_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    b_row_d  = b_row_q;
    c_row_d  = c_row_q;
    step_a_d = step_a_q;
    step_b_d = step_b_q;
    step_c_d = step_c_q;
    b_tail_d = b_tail_q;
    b_last_d = b_last_q;
    if (init) begin
      // Products are formed once per job and held; the tile walk only adds.
      n_d      = '0;
      m_d      = '0;
      k_d      = '0;
      a_row_d  = '0;
      b_row_d  = '0;
      c_row_d  = '0;
      step_a_d = 32'(BLK_M) * {16'd0, dim_k};
      step_b_d = 32'(BLK_K) * {16'd0, dim_n};
      step_c_d = 32'(BLK_M) * {16'd0, dim_n};
      b_tail_d = 32'(BLK_K - 1) * {16'd0, dim_n};
      b_last_d = {16'd0, dim_k - 16'd1} * {16'd0, dim_n};
    end else if (advance) begin
      if (!k_last) begin
        k_d     = k_end[15:0];
        b_row_d = b_row_q + step_b_q;
      end else begin
        k_d     = '0;
        b_row_d = '0;
        if (!m_last) begin
          m_d     = m_end[15:0];
          a_row_d = a_row_q + step_a_q;
          c_row_d = c_row_q + step_c_q;
        end else begin
          m_d     = '0;
          a_row_d = '0;
          c_row_d = '0;
          n_d     = n_end[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_q      <= '0;
      m_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      b_row_q  <= '0;
      c_row_q  <= '0;
      step_a_q <= '0;
      step_b_q <= '0;
      step_c_q <= '0;
      b_tail_q <= '0;
      b_last_q <= '0;
    end else begin
      n_q      <= n_d;
      m_q      <= m_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      b_row_q  <= b_row_d;
      c_row_q  <= c_row_d;
      step_a_q <= step_a_d;
      step_b_q <= step_b_d;
      step_c_q <= step_c_d;
      b_tail_q <= b_tail_d;
      b_last_q <= b_last_d;
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Bus master that tiles C = A x B onto the GEMM register file, one tile per
// 7-write + poll burst. Optional poll watchdog: GEMM_SEQ_TIMEOUT_EN.
module gemm_tile_sequencer
  import gemm_seq_pkg::*;
#(
  parameter int          BLK_N          = 16,
  parameter int          BLK_K          = 16,
  parameter int          BLK_M          = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h9000_0000,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_m,
  input  logic [15:0] cfg_k,
  input  logic [15:0] cfg_n,
  input  logic [31:0] cfg_a_base,
  input  logic [31:0] cfg_b_base,
  input  logic [31:0] cfg_c_base,
  output logic        busy,
  output logic        done,
  output logic        err,
  gemm_tile_sequencer_if.master system_bus
);

  seq_state_e  state_q, state_d;
  logic [15:0] dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [31:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic        busy_q, busy_d, done_q, done_d, en_q, en_d, rdwr_q, rdwr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        init, advance, zero_cur, zero_next;

  logic [31:0] a_addr, b_addr, c_addr, dim_word;
  logic [1:0]  ctrl;
  logic        blk_done, all_done;
  logic        unused_rd_bits;

`ifdef GEMM_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  assign unused_rd_bits = ^system_bus.rd_data[31:1];
  assign zero_cur = (dim_m_q == 16'd0) || (dim_k_q == 16'd0) || (dim_n_q == 16'd0);

  gemm_tile_iter #(.BLK_N(BLK_N), .BLK_K(BLK_K), .BLK_M(BLK_M)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .advance  (advance),
    .dim_m    (dim_m_q),
    .dim_k    (dim_k_q),
    .dim_n    (dim_n_q),
    .a_base   (a_base_q),
    .b_base   (b_base_q),
    .c_base   (c_base_q),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .c_addr   (c_addr),
    .ctrl     (ctrl),
    .dim_word (dim_word),
    .blk_done (blk_done),
    .all_done (all_done)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    dim_m_d  = dim_m_q;
    dim_k_d  = dim_k_q;
    dim_n_d  = dim_n_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    init     = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) begin
        dim_m_d  = cfg_m;
        dim_k_d  = cfg_k;
        dim_n_d  = cfg_n;
        a_base_d = cfg_a_base;
        b_base_d = cfg_b_base;
        c_base_d = cfg_c_base;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        init    = 1'b1;
        state_d = zero_cur ? S_FIN : S_WR_ASTR;
      end
      S_WR_ASTR: state_d = S_WR_BSTR;
      S_WR_BSTR: state_d = S_WR_AADR;
      S_WR_AADR: state_d = S_WR_BADR;
      S_WR_BADR: state_d = S_WR_CADR;
      S_WR_CADR: state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_WR_DIM;
      S_WR_DIM:  state_d = S_POLL_FULL;
      S_POLL_FULL: if (!system_bus.rd_data[0]) begin
        if (blk_done) begin
          state_d = S_POLL_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_WR_ASTR;
        end
      end
      S_POLL_DONE: if (system_bus.rd_data[0]) begin
        if (all_done) begin
          state_d = S_FIN;
        end else begin
          advance = 1'b1;
          state_d = S_WR_ASTR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef GEMM_SEQ_TIMEOUT_EN
    // Counter runs only while stalled in a poll state; any move clears it.
    cnt_d = '0;
    err_d = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if ((state_q == S_POLL_FULL || state_q == S_POLL_DONE) && state_d == state_q) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_FIN;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif

    zero_next = (dim_m_d == 16'd0) || (dim_k_d == 16'd0) || (dim_n_d == 16'd0);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FIN) && !zero_next;

    // Outputs are decoded from the next state so the bus is registered.
    en_d    = 1'b0;
    rdwr_d  = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    unique case (state_d)
      S_WR_ASTR: begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + REG_A_STRIDE; wdata_d = 32'(dim_k_d); end
      S_WR_BSTR: begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + REG_B_STRIDE; wdata_d = 32'(dim_n_d); end
      S_WR_AADR: begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + REG_A_ADDR;   wdata_d = a_addr; end
      S_WR_BADR: begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + REG_B_ADDR;   wdata_d = b_addr; end
      S_WR_CADR: begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + REG_C_ADDR;   wdata_d = c_addr; end
      S_WR_CTRL: begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + REG_CTRL;     wdata_d = 32'(ctrl); end
      S_WR_DIM:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + REG_DIM;      wdata_d = dim_word; end
      S_POLL_FULL: begin en_d = 1'b1; addr_d = BASE_ADDR + REG_A_ADDR; end
      S_POLL_DONE: begin en_d = 1'b1; addr_d = BASE_ADDR + REG_DIM; end
      S_FIN:     done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q  <= S_IDLE;
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      rdwr_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      dim_m_q  <= dim_m_d;
      dim_k_q  <= dim_k_d;
      dim_n_q  <= dim_n_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      rdwr_q   <= rdwr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef GEMM_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign system_bus.en      = en_q;
  assign system_bus.rdwr    = rdwr_q;
  assign system_bus.addr    = addr_q;
  assign system_bus.wr_data = wdata_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: tile order/addresses, latency,
// back-pressure, zero-size jobs, mid-job reset and (optionally) the watchdog.
module tb_gemm_tile_sequencer;
  import gemm_seq_pkg::*;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
  logic [31:0] cfg_a = '0, cfg_b = '0, cfg_c = '0;
  logic        busy, done, err;
  logic        full_bit = 1'b0;
  logic        done_bit = 1'b1;

  gemm_tile_sequencer_if sb();

  gemm_tile_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_m      (cfg_m),
    .cfg_k      (cfg_k),
    .cfg_n      (cfg_n),
    .cfg_a_base (cfg_a),
    .cfg_b_base (cfg_b),
    .cfg_c_base (cfg_c),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .system_bus (sb)
  );

  always #5 clk = ~clk;

  // GEMM top stand-in: BASE+0 returns "full", BASE+24 returns "done".
  always_comb sb.rd_data = (sb.addr == BASE) ? {31'd0, full_bit} : {31'd0, done_bit};

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int poll_done_cnt = 0, done_cnt = 0, en_cnt = 0;
  int n_checks = 0, n_pass = 0;

  always @(negedge clk) begin
    if (sb.en && sb.rdwr) begin
      wr_addr.push_back(sb.addr);
      wr_data.push_back(sb.wr_data);
    end
    if (sb.en && !sb.rdwr && sb.addr == BASE + 32'd24) poll_done_cnt++;
    if (sb.en) en_cnt++;
    if (done) done_cnt++;
  end

  // Tile checks for M=K=N=20: write index and expected data.
  localparam int MT_IDX [27] = '{0, 1, 2, 3, 4, 5, 6, 9, 10, 11, 12, 13,
                                 16, 17, 18, 19, 20, 30, 31, 32, 33, 34,
                                 51, 52, 53, 54, 55};
  localparam int MT_VAL [27] = '{20, 20, 0, 700, 800, 2, 16912, 16, 780, 800, 1, 16528,
                                 320, 700, 1120, 2, 16900, 0, 716, 816, 2, 4624,
                                 336, 796, 1136, 1, 4228};
  localparam int T1_OFF [7] = '{12, 16, 0, 4, 8, 20, 24};

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    poll_done_cnt = 0;
    done_cnt      = 0;
    en_cnt        = 0;
  endtask

  task automatic start_job(input logic [15:0] m, k, n, input logic [31:0] a, b, c);
    cfg_m = m; cfg_k = k; cfg_n = n;
    cfg_a = a; cfg_b = b; cfg_c = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    n_checks++;
    if (done !== 1'b1) $display("FAIL %s_done_timeout done=%b expected 1 within %0d cycles", name, done, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if ({sb.en, sb.rdwr, busy, done, err} !== 5'b0) $display("FAIL reset_ctrl got %b expected 00000", {sb.en, sb.rdwr, busy, done, err});
    else n_pass++;
    n_checks++;
    if ({sb.addr, sb.wr_data} !== 64'd0) $display("FAIL reset_bus got %h expected 0", {sb.addr, sb.wr_data});
    else n_pass++;
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({sb.en, busy, done} !== 3'b0) $display("FAIL idle_after_reset got %b expected 000", {sb.en, busy, done});
    else n_pass++;
  endtask

  task automatic test_single_tile();
    clear_log();
    start_job(16, 16, 16, 32'd100, 32'd200, 32'd300);
    n_checks++;
    if ({busy, sb.en} !== 2'b10) $display("FAIL st_load got busy/en=%b expected 10", {busy, sb.en});
    else n_pass++;
    tick();
    n_checks++;
    if ({sb.en, sb.rdwr} !== 2'b11 || sb.addr !== BASE + 32'd12 || sb.wr_data !== 32'd16)
      $display("FAIL st_first_write got en=%b rdwr=%b addr=%h data=%0d expected 1 1 %h 16",
               sb.en, sb.rdwr, sb.addr, sb.wr_data, BASE + 32'd12);
    else n_pass++;
    wait_done(40, "st");
    n_checks++;
    if (en_cnt !== 9 || wr_addr.size() !== 7 || poll_done_cnt !== 1)
      $display("FAIL st_bus_cycles got en=%0d writes=%0d polldone=%0d expected 9 7 1", en_cnt, wr_addr.size(), poll_done_cnt);
    else n_pass++;
    if (wr_data.size() == 7) begin
      n_checks++;
      if (wr_data[2] !== 32'd100 || wr_data[3] !== 32'd440 || wr_data[4] !== 32'd300)
        $display("FAIL st_addrs got %0d %0d %0d expected 100 440 300", wr_data[2], wr_data[3], wr_data[4]);
      else n_pass++;
      n_checks++;
      if (wr_data[5] !== 32'd3 || wr_data[6] !== 32'd16912)
        $display("FAIL st_ctrl_dim got %0d %0d expected 3 16912", wr_data[5], wr_data[6]);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00 || done_cnt !== 1) $display("FAIL st_done_pulse got done=%b busy=%b pulses=%0d expected 0 0 1", done, busy, done_cnt);
    else n_pass++;
  endtask

  task automatic test_multi_tile();
    clear_log();
    start_job(20, 20, 20, 32'd0, 32'd400, 32'd800);
    wait_done(400, "mt");
    tick();
    n_checks++;
    if (wr_addr.size() !== 56 || poll_done_cnt !== 2 || done_cnt !== 1)
      $display("FAIL mt_counts got writes=%0d polldone=%0d done=%0d expected 56 2 1", wr_addr.size(), poll_done_cnt, done_cnt);
    else n_pass++;
    if (wr_addr.size() >= 56) begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (wr_addr[i] !== BASE + 32'(T1_OFF[i])) $display("FAIL mt_order_%0d got %h expected %h", i, wr_addr[i], BASE + 32'(T1_OFF[i]));
        else n_pass++;
      end
      for (int i = 0; i < 27; i++) begin
        n_checks++;
        if (wr_data[MT_IDX[i]] !== 32'(MT_VAL[i])) $display("FAIL mt_write_%0d got %0d expected %0d", MT_IDX[i], wr_data[MT_IDX[i]], MT_VAL[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int  polls = 0;
    bit  saw_write = 1'b0;
    clear_log();
    full_bit = 1'b1;
    start_job(32, 16, 16, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 60 && polls < 10; i++) begin
      tick();
      if (sb.en && sb.rdwr && polls > 0) saw_write = 1'b1;
      if (sb.en && !sb.rdwr && sb.addr == BASE) polls++;
    end
    n_checks++;
    if (polls !== 10 || saw_write) $display("FAIL bp_stall got polls=%0d write_during_stall=%b expected 10 0", polls, saw_write);
    else n_pass++;
    full_bit = 1'b0;
    tick();
    n_checks++;
    if ({sb.en, sb.rdwr} !== 2'b11 || sb.addr !== BASE + 32'd12)
      $display("FAIL bp_resume got en=%b rdwr=%b addr=%h expected 1 1 %h", sb.en, sb.rdwr, sb.addr, BASE + 32'd12);
    else n_pass++;
    wait_done(60, "bp");
    n_checks++;
    if (wr_addr.size() !== 14) $display("FAIL bp_writes got %0d expected 14", wr_addr.size());
    else n_pass++;
    tick();
  endtask

  task automatic test_zero();
    clear_log();
    start_job(0, 16, 16, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL zero_edge0 got done=%b busy=%b expected 0 0", done, busy);
    else n_pass++;
    tick();
    n_checks++;
    if ({done, busy} !== 2'b10) $display("FAIL zero_edge1 got done=%b busy=%b expected 1 0", done, busy);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (done !== 1'b0 || en_cnt !== 0 || done_cnt !== 1)
      $display("FAIL zero_quiet got done=%b en_cycles=%0d pulses=%0d expected 0 0 1", done, en_cnt, done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midjob();
    int d0;
    clear_log();
    start_job(20, 20, 20, 32'd0, 32'd400, 32'd800);
    for (int i = 0; i < 200 && wr_addr.size() < 19; i++) tick();
    n_checks++;
    if (wr_addr.size() !== 19 || wr_addr[18] !== BASE + 32'd8 || wr_data[18] !== 32'd1120)
      $display("FAIL rst_at_cadr got writes=%0d addr=%h data=%0d expected 19 %h 1120",
               wr_addr.size(), wr_addr[18], wr_data[18], BASE + 32'd8);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({sb.en, sb.rdwr, busy, done, err} !== 5'b0 || {sb.addr, sb.wr_data} !== 64'd0)
      $display("FAIL rst_mid_outputs got ctrl=%b addr=%h data=%h expected all 0",
               {sb.en, sb.rdwr, busy, done, err}, sb.addr, sb.wr_data);
    else n_pass++;
    rst = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (done_cnt !== d0 || sb.en !== 1'b0) $display("FAIL rst_mid_quiet got pulses=%0d en=%b expected %0d 0", done_cnt, sb.en, d0);
    else n_pass++;
    clear_log();
    start_job(20, 20, 20, 32'd0, 32'd400, 32'd800);
    wait_done(400, "rerun");
    n_checks++;
    if (wr_addr.size() !== 56 || wr_data[3] !== 32'd700 || wr_data[6] !== 32'd16912)
      $display("FAIL rerun got writes=%0d b=%0d dim=%0d expected 56 700 16912", wr_addr.size(), wr_data[3], wr_data[6]);
    else n_pass++;
    tick();
  endtask

`ifdef GEMM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int polls = 0;
    clear_log();
    full_bit = 1'b1;
    start_job(16, 16, 16, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 60 && done !== 1'b1; i++) begin
      tick();
      if (sb.en && !sb.rdwr) polls++;
    end
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1 || polls !== 8 || sb.en !== 1'b0)
      $display("FAIL to_trip got done=%b err=%b polls=%0d en=%b expected 1 1 8 0", done, err, polls, sb.en);
    else n_pass++;
    full_bit = 1'b0;
    tick(); tick();
    n_checks++;
    if (err !== 1'b1) $display("FAIL to_sticky got err=%b expected 1", err);
    else n_pass++;
    start_job(16, 16, 16, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (err !== 1'b0) $display("FAIL to_clear got err=%b expected 0", err);
    else n_pass++;
    wait_done(40, "to_after");
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_backpressure();
    test_zero();
    test_reset_midjob();
`ifdef GEMM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
